// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: valid/ready instruction fetch responder with fixed latency, error flagging and a side load port
module imem_fetch_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h80000000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [31:0] WINDOW   = 32'd4 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 2);
    state_t                state, state_nxt;
    logic [31:0]           mem [0:(1 << DEPTH_LOG2) - 1];
    logic [31:0]           addr_q, cap_addr, off;
    logic [3:0]            cnt, cnt_nxt;
    logic                  accept, enter_resp, cap_err;
    logic [DEPTH_LOG2-1:0] cap_idx;
    assign accept     = req_valid && req_ready;
    assign enter_resp = (state_nxt == RESP) && (state != RESP || accept);
    // with LATENCY==1 the capture happens on the accepting edge, before addr_q holds the address
    assign cap_addr   = accept ? req_addr : addr_q;
    assign off        = cap_addr - BASE_ADDR;
    assign cap_err    = (cap_addr[1:0] != 2'b00) || (off >= WINDOW);
    assign cap_idx    = off[DEPTH_LOG2+1:2];
    // state, latency counter and latched fetch address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) addr_q <= req_addr;
        end
    end
    // next state: accept restarts the latency window, WAIT counts down, RESP drains on resp_ready
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (accept) begin
            state_nxt = (LATENCY == 1) ? RESP : WAIT;
            cnt_nxt   = CNT_INIT;
        end else if (state == WAIT) begin
            state_nxt = (cnt == '0) ? RESP : WAIT;
            cnt_nxt   = (cnt == '0) ? cnt : cnt - 4'd1;
        end else if (state == RESP && resp_ready) begin
            state_nxt = IDLE;
        end
    end
    // handshake outputs decoded from state
    always_comb begin
        resp_valid = (state == RESP);
        req_ready  = (state == IDLE) || (state == RESP && resp_ready);
    end
    // response word captured once on RESP entry and held until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else if (enter_resp) begin
            resp_err  <= cap_err;
            resp_data <= cap_err ? 32'd0 : mem[cap_idx];
        end
    end
    // load port write; no reset so the store maps onto block RAM
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end
endmodule
